// File: rtl/bb_ram_pkg.sv
// Shared types and constants for the byte-lane parametrised block RAM.
package bb_ram_pkg;

  // Every lane is one byte wide; the data word is built from NL lanes.
  localparam int LANE_W = 8;

  // Supported read latencies: 1 = RAM read register only, 2 = extra output register.
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Array sequencer: CLEAR zero-fills the whole array, RUN serves accesses.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Number of byte lanes for a given data width.
  function automatic int lane_count(input int data_w);
    return data_w / LANE_W;
  endfunction

  // True when the requested read latency is one the datapath implements.
  function automatic bit rd_lat_legal(input int lat);
    return (lat == RD_LAT_MIN) || (lat == RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/bb_ram_lane.sv
// One byte lane: DEPTH x 8 single-port synchronous RAM with a registered read.
// FORWARD selects what a read returns when it coincides with a write to the
// same (necessarily identical, single-port) address: the new byte or the old one.
module bb_ram_lane
  import bb_ram_pkg::*;
#(
  parameter int ADDR_W  = 11,
  parameter int FORWARD = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LANE_W-1:0] wdata_i,
  input  logic              we_i,
  input  logic              re_i,
  output logic [LANE_W-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [LANE_W-1:0] mem_q [DEPTH];
  logic [LANE_W-1:0] rdata_q;
  logic              fwd_s;

  // Forwarding applies only when this lane is written in the reading cycle.
  assign fwd_s = (FORWARD != 0) && we_i;

  // Storage array write port; the array itself is never reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read register: loads on every read, otherwise holds the last result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= {LANE_W{1'b0}};
    end else if (re_i) begin
      rdata_q <= fwd_s ? wdata_i : mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bb_ram_param.sv
// Parametrised byte-lane single-port RAM with a word-addressed interface.
// After reset an optional sequencer zero-fills every word; ready stays low
// until the fill completes and accesses are ignored meanwhile. Reads return
// one result per enabled cycle with a latency of RD_LAT edges and a one-cycle
// rd_valid strobe. INIT_FILE is reserved for flows that preload the array and
// only has to be consistent with CLEAR_ON_RESET.
module bb_ram_param
  import bb_ram_pkg::*;
#(
  parameter int    DATA_W         = 32,
  parameter int    ADDR_W         = 11,
  parameter int    RD_LAT         = 1,
  parameter int    FORWARD        = 1,
  parameter int    CLEAR_ON_RESET = 1,
  parameter string INIT_FILE      = ""
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [ADDR_W-1:0]                    addr,
  input  logic [DATA_W-1:0]                    data_in,
  input  logic [lane_count(DATA_W)-1:0]        we,
  input  logic                                 en,
  output logic [DATA_W-1:0]                    data_out,
  output logic                                 rd_valid,
  output logic                                 ready
);

  localparam int NL = lane_count(DATA_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam state_e RESET_ST = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  // Elaboration-time parameter sanity checks.
  if ((DATA_W <= 0) || ((DATA_W % LANE_W) != 0)) begin : g_bad_width
    $error("bb_ram_param: DATA_W must be a positive multiple of 8");
  end
  if (!rd_lat_legal(RD_LAT)) begin : g_bad_lat
    $error("bb_ram_param: RD_LAT must be 1 or 2");
  end
  if ((INIT_FILE != "") && (CLEAR_ON_RESET != 0)) begin : g_bad_init
    $error("bb_ram_param: INIT_FILE requires CLEAR_ON_RESET=0");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              ready_q, ready_d;
  logic              rd_v1_q, rd_v1_d;

  logic              clear_s;
  logic [ADDR_W-1:0] ram_addr_s;
  logic [DATA_W-1:0] ram_wdata_s;
  logic [NL-1:0]     ram_we_s;
  logic              ram_re_s;
  logic [DATA_W-1:0] ram_rdata_s;

  // Sequencer next state: walk clr_cnt to the last word, then enter RUN.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_ONE;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d   = RESET_ST;
        clr_cnt_d = {ADDR_W{1'b0}};
      end
    endcase
    ready_d = (state_d == ST_RUN);
  end

  // Port mux: the sequencer owns the array while clearing, the user otherwise.
  always_comb begin
    clear_s = (state_q == ST_CLEAR);
    if (clear_s) begin
      ram_addr_s  = clr_cnt_q;
      ram_wdata_s = {DATA_W{1'b0}};
      ram_we_s    = {NL{1'b1}};
      ram_re_s    = 1'b0;
    end else begin
      ram_addr_s  = addr;
      ram_wdata_s = data_in;
      ram_we_s    = en ? we : {NL{1'b0}};
      ram_re_s    = en;
    end
    rd_v1_d = ram_re_s;
  end

  // Sequencer state, ready flag and first read-valid stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RESET_ST;
      clr_cnt_q <= {ADDR_W{1'b0}};
      ready_q   <= 1'b0;
      rd_v1_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
      rd_v1_q   <= rd_v1_d;
    end
  end

  for (genvar g = 0; g < NL; g++) begin : g_lane
    bb_ram_lane #(
      .ADDR_W  (ADDR_W),
      .FORWARD (FORWARD)
    ) u_lane (
      .clk_i   (clk),
      .rst_i   (reset),
      .addr_i  (ram_addr_s),
      .wdata_i (ram_wdata_s[g*LANE_W +: LANE_W]),
      .we_i    (ram_we_s[g]),
      .re_i    (ram_re_s),
      .rdata_o (ram_rdata_s[g*LANE_W +: LANE_W])
    );
  end

  if (RD_LAT == RD_LAT_MIN) begin : g_lat1
    assign data_out = ram_rdata_s;
    assign rd_valid = rd_v1_q;
  end else begin : g_lat2
    logic              rd_v2_q;
    logic [DATA_W-1:0] dout_q;

    // Output register: captures each read result one edge after the RAM.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rd_v2_q <= 1'b0;
        dout_q  <= {DATA_W{1'b0}};
      end else begin
        rd_v2_q <= rd_v1_q;
        if (rd_v1_q) begin
          dout_q <= ram_rdata_s;
        end
      end
    end

    assign data_out = dout_q;
    assign rd_valid = rd_v2_q;
  end

  assign ready = ready_q;

endmodule

// File: tb/tb_bb_ram_param.sv
// Self-checking bench: two 16 x 32 instances share one stimulus stream.
// A: RD_LAT=1, FORWARD=1 (write-first). B: RD_LAT=2, FORWARD=0 (read-first).
module tb_bb_ram_param;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] addr;
  logic [31:0]   data_in;
  logic [3:0]    we;
  logic          en;
  logic [31:0]   dout_a, dout_b;
  logic          rv_a, rv_b, rdy_a, rdy_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bb_ram_param #(.DATA_W(32), .ADDR_W(AW), .RD_LAT(1), .FORWARD(1), .CLEAR_ON_RESET(1)) u_a (
    .clk(clk), .reset(reset), .addr(addr), .data_in(data_in), .we(we), .en(en),
    .data_out(dout_a), .rd_valid(rv_a), .ready(rdy_a)
  );

  bb_ram_param #(.DATA_W(32), .ADDR_W(AW), .RD_LAT(2), .FORWARD(0), .CLEAR_ON_RESET(1)) u_b (
    .clk(clk), .reset(reset), .addr(addr), .data_in(data_in), .we(we), .en(en),
    .data_out(dout_b), .rd_valid(rv_b), .ready(rdy_b)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    we;
    logic          en;
    logic [31:0]   exp_a;
    logic [31:0]   exp_b;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] w, input logic e);
    addr    = a;
    data_in = d;
    we      = w;
    en      = e;
  endtask

  initial begin
    // addr, wdata, we, en, expected A (write-first, 1 cycle), expected B (read-first, 2 cycles)
    vecs[0]  = '{4'd3,  32'hAABBCCDD, 4'b1111, 1'b1, 32'hAABBCCDD, 32'h00000000};
    vecs[1]  = '{4'd3,  32'h11223344, 4'b0101, 1'b1, 32'hAA22CC44, 32'hAABBCCDD};
    vecs[2]  = '{4'd3,  32'h00000000, 4'b0000, 1'b1, 32'hAA22CC44, 32'hAA22CC44};
    vecs[3]  = '{4'd5,  32'h12345678, 4'b1111, 1'b1, 32'h12345678, 32'h00000000};
    vecs[4]  = '{4'd5,  32'hFFFFFFFF, 4'b0011, 1'b1, 32'h1234FFFF, 32'h12345678};
    vecs[5]  = '{4'd5,  32'h00000000, 4'b0000, 1'b1, 32'h1234FFFF, 32'h1234FFFF};
    vecs[6]  = '{4'd7,  32'h0000BEEF, 4'b1111, 1'b1, 32'h0000BEEF, 32'h00000000};
    vecs[7]  = '{4'd7,  32'hDEADDEAD, 4'b1111, 1'b0, 32'h00000000, 32'h00000000};
    vecs[8]  = '{4'd7,  32'h00000000, 4'b0000, 1'b1, 32'h0000BEEF, 32'h0000BEEF};
    vecs[9]  = '{4'd1,  32'h00000001, 4'b1111, 1'b1, 32'h00000001, 32'h00000000};
    vecs[10] = '{4'd2,  32'h00000002, 4'b1111, 1'b1, 32'h00000002, 32'h00000000};
    vecs[11] = '{4'd3,  32'h00000003, 4'b1111, 1'b1, 32'h00000003, 32'hAA22CC44};
    vecs[12] = '{4'd15, 32'h00000000, 4'b0000, 1'b1, 32'h00000000, 32'h00000000};

    reset = 1'b1;
    drive(4'd0, 32'h0, 4'b0000, 1'b0);
    tick;
    tick;
    check("reset ready_a",    32'(rdy_a), 32'd0);
    check("reset ready_b",    32'(rdy_b), 32'd0);
    check("reset rd_valid_a", 32'(rv_a),  32'd0);
    check("reset rd_valid_b", 32'(rv_b),  32'd0);
    check("reset data_out_a", dout_a,     32'h0);
    check("reset data_out_b", dout_b,     32'h0);

    // Clear timing: ready low for 15 edges, high after the 16th.
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick;
      check($sformatf("clear ready_a edge %0d", i), 32'(rdy_a), (i == 16) ? 32'd1 : 32'd0);
      check($sformatf("clear ready_b edge %0d", i), 32'(rdy_b), (i == 16) ? 32'd1 : 32'd0);
    end

    // Back-to-back reads of the freshly cleared array.
    for (int i = 0; i < 16; i++) begin
      drive(AW'(i), 32'h0, 4'b0000, 1'b1);
      tick;
      check($sformatf("clr rd_valid_a %0d", i), 32'(rv_a), 32'd1);
      check($sformatf("clr data_a %0d", i), dout_a, 32'h0);
      check($sformatf("clr rd_valid_b %0d", i), 32'(rv_b), (i > 0) ? 32'd1 : 32'd0);
      if (i > 0) begin
        check($sformatf("clr data_b %0d", i), dout_b, 32'h0);
      end else begin
        check("clr data_b idle", dout_b, 32'h0);
      end
    end
    drive(4'd0, 32'h0, 4'b0000, 1'b0);
    tick;
    check("clr tail rd_valid_a", 32'(rv_a), 32'd0);
    check("clr tail rd_valid_b", 32'(rv_b), 32'd1);
    check("clr tail data_b",     dout_b,    32'h0);
    tick;

    // Table: one access, then one idle cycle to see B's second-stage result.
    for (int v = 0; v < 13; v++) begin
      drive(vecs[v].addr, vecs[v].wdata, vecs[v].we, vecs[v].en);
      tick;
      check($sformatf("vec%0d rd_valid_a", v), 32'(rv_a), 32'(vecs[v].en));
      if (vecs[v].en) begin
        check($sformatf("vec%0d data_a", v), dout_a, vecs[v].exp_a);
      end else begin
        check($sformatf("vec%0d rd_valid_b early", v), 32'(rv_b), 32'd0);
      end
      drive(4'd0, 32'h0, 4'b0000, 1'b0);
      tick;
      check($sformatf("vec%0d rd_valid_b", v), 32'(rv_b), 32'(vecs[v].en));
      check($sformatf("vec%0d rd_valid_a idle", v), 32'(rv_a), 32'd0);
      if (vecs[v].en) begin
        check($sformatf("vec%0d data_b", v), dout_b, vecs[v].exp_b);
      end else begin
        check($sformatf("vec%0d data_a held", v), dout_a, vecs[v-1].exp_a);
      end
    end

    // Latency: back-to-back reads of 1,2,3; B delivers on edges 2,3,4.
    drive(4'd1, 32'h0, 4'b0000, 1'b1);
    tick;
    check("lat e1 rd_valid_b", 32'(rv_b), 32'd0);
    check("lat e1 data_a",     dout_a,    32'h1);
    drive(4'd2, 32'h0, 4'b0000, 1'b1);
    tick;
    check("lat e2 rd_valid_b", 32'(rv_b), 32'd1);
    check("lat e2 data_b",     dout_b,    32'h1);
    check("lat e2 data_a",     dout_a,    32'h2);
    drive(4'd3, 32'h0, 4'b0000, 1'b1);
    tick;
    check("lat e3 rd_valid_b", 32'(rv_b), 32'd1);
    check("lat e3 data_b",     dout_b,    32'h2);
    check("lat e3 data_a",     dout_a,    32'h3);
    drive(4'd0, 32'h0, 4'b0000, 1'b0);
    tick;
    check("lat e4 rd_valid_b", 32'(rv_b), 32'd1);
    check("lat e4 data_b",     dout_b,    32'h3);
    check("lat e4 rd_valid_a", 32'(rv_a), 32'd0);
    tick;
    check("lat e5 rd_valid_b", 32'(rv_b), 32'd0);
    check("lat e5 data_b held", dout_b,   32'h3);
    check("lat e5 data_a held", dout_a,   32'h3);

    // A read in flight in B is discarded when reset asserts.
    drive(4'd3, 32'h0, 4'b0000, 1'b1);
    tick;
    drive(4'd0, 32'h0, 4'b0000, 1'b0);
    reset = 1'b1;
    #1;
    check("flush rd_valid_b", 32'(rv_b), 32'd0);
    check("flush data_b",     dout_b,    32'h0);
    check("flush data_a",     dout_a,    32'h0);
    check("flush ready_a",    32'(rdy_a), 32'd0);
    tick;
    reset = 1'b0;

    // Reset mid-clear at clr_cnt=9, then a write attempted during CLEAR.
    repeat (9) tick;
    check("midclr ready_a", 32'(rdy_a), 32'd0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      if (i >= 10 && i <= 14) begin
        drive(4'd7, 32'hDEADBEEF, 4'b1111, 1'b1);
      end else begin
        drive(4'd0, 32'h0, 4'b0000, 1'b0);
      end
      tick;
      check($sformatf("reclr ready_a edge %0d", i), 32'(rdy_a), (i == 16) ? 32'd1 : 32'd0);
      check($sformatf("reclr ready_b edge %0d", i), 32'(rdy_b), (i == 16) ? 32'd1 : 32'd0);
      check($sformatf("reclr rd_valid_a edge %0d", i), 32'(rv_a), 32'd0);
      check($sformatf("reclr rd_valid_b edge %0d", i), 32'(rv_b), 32'd0);
    end
    drive(4'd7, 32'h0, 4'b0000, 1'b1);
    tick;
    check("lost write rd_valid_a", 32'(rv_a), 32'd1);
    check("lost write data_a",     dout_a,    32'h0);
    drive(4'd0, 32'h0, 4'b0000, 1'b0);
    tick;
    check("lost write rd_valid_b", 32'(rv_b), 32'd1);
    check("lost write data_b",     dout_b,    32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
